bram_window_fetch: RTL and testbench
====================================

Name: bram_window_fetch

Overview:
- Read-side sequencer that sits directly downstream of the 32-bit single-port feature-map BRAM.
- Walks a stored H x W feature map in KxK sliding-window order (stride S) and drives the BRAM's byte-granular read address.
- Absorbs the BRAM's 1-cycle read latency and delivers words on a valid/ready stream to the MAC array, with window and frame markers.
- A small internal FIFO provides lossless backpressure.

Parameters:
- DATA_W, 32, word width; equals the BRAM word width.
- ADDR_W, 20, width of the byte read address.
- IFM_W, 16, feature-map width in words.
- IFM_H, 16, feature-map height in words.
- KSIZE, 3, kernel side K.
- STRIDE, 1, window stride S.
- FIFO_DEPTH, 4, output buffer depth; power of 2, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame walk when idle.
- bram_we  in  1  mirror of the BRAM write enable; while high no read is issued.
- rd_addr  out  ADDR_W  byte address to the BRAM; word index << 2.
- bram_dout  in  DATA_W  BRAM read data, valid 1 cycle after the address is presented.
- m_valid  out  1  stream word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  window element.
- m_win_last  out  1  last (ky=K-1, kx=K-1) element of a window.
- m_frame_last  out  1  last element of the last window.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Derived sizes: OH=(IFM_H-K)/S+1, OW=(IFM_W-K)/S+1.
- Word index = (oy*S+ky)*IFM_W + (ox*S+kx). rd_addr = index<<2, truncated to ADDR_W.
- Loop order, innermost first: kx, ky, ox, oy.
- Reset values: rd_addr=0, m_valid=0, m_data=0, m_win_last=0, m_frame_last=0, busy=0, done=0. Reset also clears the FIFO, the in-flight flag and all counters.
- FSM states:
  - IDLE: start -> RUN, counters cleared, busy=1. start while not in IDLE is ignored.
  - RUN: a read is issued in a cycle iff bram_we=0 and (fifo_count + inflight) < FIFO_DEPTH. On issue, rd_addr takes that element's address, the counters advance, and inflight is set for the next cycle. After the final element is issued -> DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty with its last word accepted, then pulse done=1 for one cycle, set busy=0 and return to IDLE.
- Read latency:
  - An element issued in cycle t is captured from bram_dout in cycle t+1 and written to the FIFO together with its win_last/frame_last tags.
  - Earliest m_valid is 2 cycles after start.
  - With m_ready held at 1 and bram_we=0, throughput is 1 word per cycle.
- A stall on bram_we holds rd_addr and the counters. The BRAM returns 0 on write cycles, so no read may overlap a write.
- Stream rules:
  - m_data, m_win_last and m_frame_last are stable while m_valid=1 and m_ready=0.
  - A transfer occurs on m_valid & m_ready.
  - A simultaneous FIFO push and pop leaves the count unchanged.
- The FIFO never overflows: the issue gate counts the in-flight read.
- rd_addr keeps its last value when no read is issued.
- reset takes priority over every other input. Reset asserted mid-frame aborts the walk, drops all buffered words and does not pulse done.

Test Plan:
- IFM 4x4, K=3, S=1, start with m_ready=1 -> 36 words, 2x2 windows. First window rd_addr sequence 0,4,8,16,20,24,32,36,40. Second window starts at 4. m_win_last on words 9/18/27/36; m_frame_last only on word 36. done is 1 cycle after word 36.
- IFM 5x5, K=3, S=2 -> OH=OW=2. Window (oy=0,ox=1) first address 8. Window (1,0) first address 40. Last window's final address 96.
- Preload BRAM word i = i+100 and hold m_ready=0 for 8 cycles after start -> exactly 4 reads are issued, then rd_addr freezes. m_data holds 100 stably. After m_ready=1, the order 100,101,102,104,... is intact with no loss or duplicate.
- Raise bram_we for 3 cycles mid-window -> no rd_addr change and no zero words on m_data. The sequence resumes in order.
- start pulsed again while busy -> ignored. Word count stays 36 and done pulses once.
- Assert reset after 10 accepted words -> the next cycle has m_valid=0 and busy=0, with no done pulse. A new start restarts from address 0.

Source files
------------

// File: rtl/bram_window_fetch.sv
`default_nettype none
// =============================================================================
// bram_window_fetch : KxK sliding-window read sequencer for the feature-map BRAM
// Revision: 1.0
// =============================================================================
module bram_window_fetch #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 20,
  parameter int IFM_W      = 16,
  parameter int IFM_H      = 16,
  parameter int KSIZE      = 3,
  parameter int STRIDE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bram_we,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_win_last,
  output logic              m_frame_last,
  output logic              busy,
  output logic              done
);

  localparam int c_OH = (IFM_H - KSIZE) / STRIDE + 1;
  localparam int c_OW = (IFM_W - KSIZE) / STRIDE + 1;
  localparam int c_CW = 16;
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_NW = c_PW + 1;
  localparam int c_EW = DATA_W + 2;

  localparam logic [c_CW-1:0] c_K_MAX     = c_CW'(KSIZE - 1);
  localparam logic [c_CW-1:0] c_OW_MAX    = c_CW'(c_OW - 1);
  localparam logic [c_CW-1:0] c_OH_MAX    = c_CW'(c_OH - 1);
  localparam logic [31:0]     c_STRIDE_U  = STRIDE;
  localparam logic [31:0]     c_IFM_W_U   = IFM_W;
  localparam logic [c_NW-1:0] c_DEPTH     = c_NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_kx, r_ky, r_ox, r_oy;
  logic              r_inflight, r_if_wl, r_if_fl;
  logic [ADDR_W-1:0] r_last_addr;

  logic [c_EW-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_NW-1:0]   r_count;

  logic [31:0]       w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic [c_NW-1:0]   w_occ;
  logic              w_issue, w_win_last, w_last_elem, w_push, w_pop;
  logic [c_EW-1:0]   w_head;

  assign w_idx  = (32'(r_oy) * c_STRIDE_U + 32'(r_ky)) * c_IFM_W_U
                + 32'(r_ox) * c_STRIDE_U + 32'(r_kx);
  assign w_addr = ADDR_W'(w_idx << 2);

  // The outstanding read is counted so a word already on its way always has a slot.
  assign w_occ   = r_count + c_NW'(r_inflight);
  assign w_issue = !reset && !bram_we && (w_occ < c_DEPTH)
                && ((r_state == S_RUN) || ((r_state == S_IDLE) && start));

  assign w_win_last  = (r_kx == c_K_MAX) && (r_ky == c_K_MAX);
  assign w_last_elem = w_win_last && (r_ox == c_OW_MAX) && (r_oy == c_OH_MAX);

  // Address is presented in the issue cycle so the BRAM samples it under the same bram_we.
  assign rd_addr = w_issue ? w_addr : r_last_addr;

  assign w_push       = r_inflight;
  assign m_valid      = (r_count != '0);
  assign w_pop        = m_valid && m_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign m_data       = w_head[DATA_W-1:0];
  assign m_win_last   = w_head[DATA_W];
  assign m_frame_last = w_head[DATA_W+1];

  // Counters wrap to zero after the final element, so they are already cleared in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_kx        <= '0;
      r_ky        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_inflight  <= 1'b0;
      r_if_wl     <= 1'b0;
      r_if_fl     <= 1'b0;
      r_last_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done       <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_wl     <= w_win_last;
        r_if_fl     <= w_last_elem;
        r_last_addr <= w_addr;
        if (r_kx != c_K_MAX) begin
          r_kx <= r_kx + 1'b1;
        end else begin
          r_kx <= '0;
          if (r_ky != c_K_MAX) begin
            r_ky <= r_ky + 1'b1;
          end else begin
            r_ky <= '0;
            if (r_ox != c_OW_MAX) begin
              r_ox <= r_ox + 1'b1;
            end else begin
              r_ox <= '0;
              r_oy <= (r_oy != c_OH_MAX) ? r_oy + 1'b1 : '0;
            end
          end
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_state <= (w_issue && w_last_elem) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue && w_last_elem) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!r_inflight && ((r_count == '0) || ((r_count == c_NW'(1)) && w_pop))) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_if_fl, r_if_wl, bram_dout};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_window_fetch.sv
`default_nettype none
// Scoreboard bench: dut_a walks a 4x4 map (K=3,S=1), dut_b a 5x5 map (K=3,S=2); BRAM word i holds i+100.
module tb_bram_window_fetch;
  localparam int DW = 32;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, we_a, ready_a, valid_a, wl_a, fl_a, busy_a, done_a;
  logic [DW-1:0] dout_a, data_a;
  logic [AW-1:0] addr_a;
  logic          rst_b, start_b, we_b, ready_b, valid_b, wl_b, fl_b, busy_b, done_b;
  logic [DW-1:0] dout_b, data_b;
  logic [AW-1:0] addr_b;

  bram_window_fetch #(.DATA_W(DW), .ADDR_W(AW), .IFM_W(4), .IFM_H(4), .KSIZE(3),
                      .STRIDE(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .bram_we(we_a), .rd_addr(addr_a),
    .bram_dout(dout_a), .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a),
    .m_win_last(wl_a), .m_frame_last(fl_a), .busy(busy_a), .done(done_a));

  bram_window_fetch #(.DATA_W(DW), .ADDR_W(AW), .IFM_W(5), .IFM_H(5), .KSIZE(3),
                      .STRIDE(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .bram_we(we_b), .rd_addr(addr_b),
    .bram_dout(dout_b), .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b),
    .m_win_last(wl_b), .m_frame_last(fl_b), .busy(busy_b), .done(done_b));

  // Synchronous-read BRAM models; a write cycle returns zero.
  always @(posedge clk) dout_a <= we_a ? '0 : DW'(addr_a >> 2) + DW'(100);
  always @(posedge clk) dout_b <= we_b ? '0 : DW'(addr_b >> 2) + DW'(100);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          wl;
    logic          fl;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int n_checks = 0, n_errors = 0;
  int acc_a = 0, done_cnt_a = 0, acc_b = 0, done_cnt_b = 0;
  bit pend_a = 0, hold_a = 0, pend_b = 0;
  logic [DW+1:0] held_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every window element in kx, ky, ox, oy order, straight from the index formula.
  task automatic push_frame(input bit to_b, input int h, input int w, input int k, input int s);
    exp_t x;
    for (int oy = 0; oy <= (h - k) / s; oy++)
      for (int ox = 0; ox <= (w - k) / s; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            x.data = DW'((oy * s + ky) * w + ox * s + kx + 100);
            x.wl   = (ky == k - 1) && (kx == k - 1);
            x.fl   = x.wl && (oy == (h - k) / s) && (ox == (w - k) / s);
            if (to_b) q_b.push_back(x);
            else      q_a.push_back(x);
          end
  endtask

  always @(negedge clk) begin
    if (rst_a) begin
      q_a.delete();
      pend_a = 0;
      hold_a = 0;
    end else begin
      if (hold_a) begin
        check("a_hold_valid", valid_a, 1);
        check("a_hold_payload", {fl_a, wl_a, data_a}, held_a);
      end
      if (done_a) begin
        done_cnt_a++;
        check("a_done_expected", pend_a, 1);
      end else if (pend_a) begin
        check("a_done_after_last", done_a, 1);
      end
      pend_a = 0;
      if (valid_a && ready_a) begin
        acc_a++;
        check("a_word_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          e_a = q_a.pop_front();
          check("a_data", data_a, e_a.data);
          check("a_win_last", wl_a, e_a.wl);
          check("a_frame_last", fl_a, e_a.fl);
          pend_a = e_a.fl;
        end
      end
      hold_a = valid_a && !ready_a;
      held_a = {fl_a, wl_a, data_a};
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (done_b) begin
        done_cnt_b++;
        check("b_done_expected", pend_b, 1);
      end else if (pend_b) begin
        check("b_done_after_last", done_b, 1);
      end
      pend_b = 0;
      if (valid_b && ready_b) begin
        acc_b++;
        check("b_word_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          e_b = q_b.pop_front();
          check("b_data", data_b, e_b.data);
          check("b_win_last", wl_b, e_b.wl);
          check("b_frame_last", fl_b, e_b.fl);
          pend_b = e_b.fl;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int p_ready, input int p_we, input int budget);
    int n = 0;
    do begin
      step();
      start_a = 1'b0;
      ready_a = ($urandom_range(99) < p_ready);
      we_a    = ($urandom_range(99) < p_we);
      @(negedge clk);
      n++;
    end while (busy_a && n < budget);
    check("a_frame_timeout", busy_a, 0);
    step();
    we_a    = 1'b0;
    ready_a = 1'b1;
  endtask

  task automatic frame_end_a(input int base, input int dbase);
    check("a_word_count", acc_a - base, 36);
    check("a_done_pulses", done_cnt_a - dbase, 1);
    check("a_queue_drained", q_a.size(), 0);
  endtask

  int base, dbase, n;
  logic [AW-1:0] snap;

  initial begin
    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0; we_a = 0; we_b = 0;
    ready_a = 1; ready_b = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 0; rst_b = 0;
    @(negedge clk);
    check("rst_rd_addr", addr_a, 0);
    check("rst_m_valid", valid_a, 0);
    check("rst_m_data", data_a, 0);
    check("rst_win_last", wl_a, 0);
    check("rst_frame_last", fl_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_valid", valid_b, 0);

    // Frame 1 on both DUTs, plus a start re-pulse on dut_a while it is busy.
    push_frame(0, 4, 4, 3, 1);
    push_frame(1, 5, 5, 3, 2);
    base = acc_a; dbase = done_cnt_a;
    step();
    start_a = 1; start_b = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("a_first_window_addr", addr_a, ((i / 3) * 4 + i % 3) * 4);
      if (i == 1) check("a_valid_latency_early", valid_a, 0);
      if (i == 2) check("a_valid_latency", valid_a, 1);
      step();
      start_a = (i == 4);
      start_b = 0;
    end
    run_a(100, 0, 200);
    frame_end_a(base, dbase);
    check("a_addr_held_after_frame", addr_a, 60);
    n = 0;
    while (busy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_frame_timeout", busy_b, 0);
    check("b_word_count", acc_b, 36);
    check("b_done_pulses", done_cnt_b, 1);
    check("b_queue_drained", q_b.size(), 0);
    check("b_last_addr", addr_b, 96);
    step();

    // Backpressure: exactly four reads, then rd_addr freezes with 100 at the head.
    push_frame(0, 4, 4, 3, 1);
    base = acc_a; dbase = done_cnt_a;
    step();
    ready_a = 0; start_a = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3) check("a_bp_addr_frozen", addr_a, 16);
      if (i >= 2) check("a_bp_head_data", data_a, 100);
      step();
      start_a = 0;
    end
    ready_a = 1;
    run_a(100, 0, 300);
    frame_end_a(base, dbase);

    // Three-cycle bram_we stall in the first window.
    push_frame(0, 4, 4, 3, 1);
    base = acc_a; dbase = done_cnt_a;
    step();
    start_a = 1; ready_a = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 5) snap = addr_a;
      if (i >= 5 && i <= 7) check("a_we_addr_hold", addr_a, 20);
      if (i == 8) check("a_we_resume_addr", addr_a, 24);
      step();
      start_a = 0;
      we_a = (i >= 4 && i <= 6);
    end
    check("a_we_snapshot", snap, 20);
    run_a(100, 0, 300);
    frame_end_a(base, dbase);

    // Random backpressure and write-stall frames.
    for (int f = 0; f < 3; f++) begin
      push_frame(0, 4, 4, 3, 1);
      base = acc_a; dbase = done_cnt_a;
      step();
      start_a = 1;
      run_a(70, 20, 2000);
      frame_end_a(base, dbase);
    end

    // Reset after 10 accepted words aborts the frame silently.
    push_frame(0, 4, 4, 3, 1);
    base = acc_a; dbase = done_cnt_a;
    step();
    start_a = 1; ready_a = 1;
    n = 0;
    do begin
      step();
      start_a = 0;
      n++;
    end while (acc_a - base < 10 && n < 100);
    check("a_reached_10_words", acc_a - base, 10);
    rst_a = 1;
    @(negedge clk);
    step();
    rst_a = 0;
    @(negedge clk);
    check("a_post_reset_valid", valid_a, 0);
    check("a_post_reset_busy", busy_a, 0);
    check("a_post_reset_done", done_a, 0);
    repeat (5) @(negedge clk);
    check("a_no_done_after_reset", done_cnt_a, dbase);

    push_frame(0, 4, 4, 3, 1);
    base = acc_a; dbase = done_cnt_a;
    step();
    start_a = 1;
    @(negedge clk);
    check("a_restart_addr", addr_a, 0);
    run_a(100, 0, 300);
    frame_end_a(base, dbase);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
